fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and hazard controller for the pipelined RISC-V core; successor to the combinational forwarding logic. It tracks in-flight destination tags across EX and up to `FWD_DEPTH` later stages, and registers per-operand forward selects for the instruction entering EX. It generates load-use stalls and a store-data bypass for load-then-store pairs, and freezes the pipeline while a load waits on a multicycle data-memory response. Sits between ID and EX, driving the EX operand muxes and the MEM store-data mux.

---
 rtl/fwd_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard controller: tracks in-flight destination tags from EX to WB, registers EX forward selects,
// raises load-use stalls, a load->store data bypass and a memory-wait freeze. Macro FWD_HAZARD_PERF_EN adds perf counters.
module fwd_hazard_ctrl #(
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]         id_rs_used,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_reg_write,
  input  logic                       id_mem_read,
  input  logic                       id_mem_write,
  input  logic                       ex_flush,
  input  logic                       mem_ready,
  output logic                       stall_id,
  output logic                       freeze,
  output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
  output logic                       mem_store_fwd,
  output logic [CNT_W-1:0]           perf_stall_cnt,
  output logic [CNT_W-1:0]           perf_freeze_cnt
);

  localparam logic [NUM_SRC-1:0] SRC1_ONLY = NUM_SRC'(2);
  localparam logic               BYPASS_OK = (FWD_DEPTH >= 2);

  logic [FWD_DEPTH:0]        r_valid;
  logic [FWD_DEPTH:0]        r_rw;
  logic [FWD_DEPTH:0]        r_mr;
  logic [FWD_DEPTH:0]        r_stfwd;
  logic [REG_AW-1:0]         r_rd [FWD_DEPTH+1];
  logic [NUM_SRC*SEL_W-1:0]  r_sel;

  logic [FWD_DEPTH-1:0]      w_match [NUM_SRC];
  logic [NUM_SRC-1:0]        w_hit_ex;
  logic                      w_ld_hit;
  logic                      w_bypass;
  logic                      w_freeze;
  logic                      w_stall;
  logic                      w_enter;
  logic [NUM_SRC*SEL_W-1:0]  w_sel_nxt;
  logic                      w_unused_tail;

  always_comb begin
    w_match  = '{default: '0};
    w_hit_ex = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        w_match[i][k] = id_rs_used[i] && r_valid[k] && r_rw[k] && (r_rd[k] != '0) &&
                        (r_rd[k] == id_rs[i*REG_AW +: REG_AW]);
      end
      w_hit_ex[i] = w_match[i][0];
    end
  end

  // A store whose only dependency on the EX load is its data operand takes the load result later instead of stalling.
  assign w_ld_hit = r_valid[0] && r_mr[0] && (|w_hit_ex);
  assign w_bypass = BYPASS_OK && w_ld_hit && id_mem_write && (w_hit_ex == SRC1_ONLY);
  assign w_freeze = r_valid[1] && r_mr[1] && !mem_ready;
  assign w_stall  = id_valid && w_ld_hit && !w_bypass && !w_freeze;
  assign w_enter  = id_valid && !w_stall && !ex_flush;

  // Scan oldest to youngest so the nearest producer's distance is the one that survives.
  always_comb begin
    w_sel_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        w_sel_nxt[i*SEL_W +: SEL_W] = w_match[i][k-1] ? SEL_W'(k) : w_sel_nxt[i*SEL_W +: SEL_W];
      end
      w_sel_nxt[i*SEL_W +: SEL_W] = ((i == 1) && w_bypass) ? '0 : w_sel_nxt[i*SEL_W +: SEL_W];
    end
    w_sel_nxt = w_enter ? w_sel_nxt : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_rw    <= '0;
      r_mr    <= '0;
      r_stfwd <= '0;
      r_sel   <= '0;
      for (int k = 0; k <= FWD_DEPTH; k++) r_rd[k] <= '0;
    end else if (!w_freeze) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_rw[k]    <= r_rw[k-1];
        r_mr[k]    <= r_mr[k-1];
        r_stfwd[k] <= r_stfwd[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
      r_valid[0] <= w_enter;
      r_rw[0]    <= w_enter && id_reg_write;
      r_mr[0]    <= w_enter && id_mem_read;
      r_stfwd[0] <= w_enter && w_bypass;
      r_rd[0]    <= w_enter ? id_rd : '0;
      r_sel      <= w_sel_nxt;
    end
  end

  assign stall_id      = w_stall;
  assign freeze        = w_freeze;
  assign ex_fwd_sel    = r_sel;
  assign mem_store_fwd = r_valid[1] && r_stfwd[1];
  // The WB entry is tracked for completeness; nothing reads its tag.
  assign w_unused_tail = ^{r_valid[FWD_DEPTH], r_rw[FWD_DEPTH], r_mr[FWD_DEPTH], r_stfwd[FWD_DEPTH], r_rd[FWD_DEPTH]};

`ifdef FWD_HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_freeze_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_freeze && (r_freeze_cnt != '1)) r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
    end
  end

  assign perf_stall_cnt  = r_stall_cnt;
  assign perf_freeze_cnt = r_freeze_cnt;
`else
  assign perf_stall_cnt  = '0;
  assign perf_freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed pipeline scenarios plus randomized traffic against an in-bench pipeline model.
module tb_fwd_hazard_ctrl;
  localparam int NS = 2;
  localparam int D  = 2;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int SW = 2;
`ifdef FWD_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [NS*AW-1:0] id_rs = '0;
  logic [NS-1:0] id_rs_used = '0;
  logic [AW-1:0] id_rd = '0;
  logic id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic ex_flush = 1'b0, mem_ready = 1'b1;
  logic stall_id, freeze, mem_store_fwd;
  logic [NS*SW-1:0] ex_fwd_sel;
  logic [CW-1:0] perf_stall_cnt, perf_freeze_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.NUM_SRC(NS), .FWD_DEPTH(D), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_flush(ex_flush), .mem_ready(mem_ready), .stall_id(stall_id), .freeze(freeze),
    .ex_fwd_sel(ex_fwd_sel), .mem_store_fwd(mem_store_fwd),
    .perf_stall_cnt(perf_stall_cnt), .perf_freeze_cnt(perf_freeze_cnt)
  );

  // Model: list of in-flight instructions, index 0 = EX, D = WB.
  typedef struct { bit v; int rd; bit rw; bit mr; bit sf; } slot_t;
  slot_t m_pipe [0:D];
  int m_sel [NS];
  int m_stall_cnt = 0;
  int m_freeze_cnt = 0;

  function automatic int src_reg(int i);
    return int'(id_rs[i*AW +: AW]);
  endfunction

  // Distance (1 = EX) to the nearest older instruction writing source i; 0 when none.
  function automatic int prod_dist(int i);
    if (!id_rs_used[i] || src_reg(i) == 0) return 0;
    for (int k = 0; k < D; k++)
      if (m_pipe[k].v && m_pipe[k].rw && m_pipe[k].rd == src_reg(i)) return k + 1;
    return 0;
  endfunction

  function automatic bit m_freeze();
    return m_pipe[1].v && m_pipe[1].mr && !mem_ready;
  endfunction

  function automatic bit m_bypass();
    return (D >= 2) && m_pipe[0].v && m_pipe[0].mr && id_mem_write && prod_dist(1) == 1 && prod_dist(0) != 1;
  endfunction

  function automatic bit m_stall();
    return id_valid && m_pipe[0].v && m_pipe[0].mr && (prod_dist(0) == 1 || prod_dist(1) == 1)
           && !m_bypass() && !m_freeze();
  endfunction

  function automatic logic [NS*SW-1:0] exp_sel();
    return {SW'(m_sel[1]), SW'(m_sel[0])};
  endfunction

  task automatic model_update();
    bit st, fz, byp, enter;
    int d0, d1;
    st = m_stall(); fz = m_freeze(); byp = m_bypass();
    d0 = prod_dist(0); d1 = prod_dist(1);
    enter = id_valid && !st && !ex_flush;
    if (!rst_n) begin
      for (int k = 0; k <= D; k++) m_pipe[k] = '{default: 0};
      m_sel = '{0, 0};
      m_stall_cnt = 0;
      m_freeze_cnt = 0;
    end else begin
      if (st && m_stall_cnt < (1 << CW) - 1) m_stall_cnt++;
      if (fz && m_freeze_cnt < (1 << CW) - 1) m_freeze_cnt++;
      if (!fz) begin
        for (int k = D; k >= 1; k--) m_pipe[k] = m_pipe[k-1];
        if (enter) begin
          m_pipe[0] = '{1'b1, int'(id_rd), id_reg_write, id_mem_read, byp};
          m_sel[0] = d0;
          m_sel[1] = byp ? 0 : d1;
        end else begin
          m_pipe[0] = '{default: 0};
          m_sel = '{0, 0};
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic issue(input int rs0, input int rs1, input logic [1:0] used, input int rd,
                       input bit rw, input bit mr, input bit mw);
    id_valid = 1'b1; id_rs = {AW'(rs1), AW'(rs0)}; id_rs_used = used; id_rd = AW'(rd);
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ex_flush = 1'b0; mem_ready = 1'b1; nop();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (ex_fwd_sel !== 4'b0000) begin n_err++; $display("FAIL reset_sel: got %b expected 0000", ex_fwd_sel); end
    n_cmp++; if (stall_id !== 1'b0 || freeze !== 1'b0) begin n_err++; $display("FAIL reset_hazard: got stall=%b freeze=%b expected 0 0", stall_id, freeze); end
    n_cmp++; if (mem_store_fwd !== 1'b0) begin n_err++; $display("FAIL reset_msf: got %b expected 0", mem_store_fwd); end
    n_cmp++; if (perf_stall_cnt !== '0 || perf_freeze_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", perf_stall_cnt, perf_freeze_cnt); end
    tick();
  endtask

  task automatic test_fwd_alu();
    do_reset();
    issue(1, 2, 2'b11, 5, 1, 0, 0); tick();
    issue(5, 5, 2'b11, 6, 1, 0, 0);
    @(negedge clk);
    n_cmp++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL alu_nostall: got %b expected 0", stall_id); end
    tick(); nop();
    @(negedge clk);
    n_cmp++; if (ex_fwd_sel !== 4'b0101) begin n_err++; $display("FAIL alu_sel: got %b expected 0101", ex_fwd_sel); end
  endtask

  task automatic test_fwd_x0();
    do_reset();
    issue(1, 1, 2'b11, 5, 1, 0, 0); tick();
    issue(0, 0, 2'b11, 0, 1, 0, 0); tick();
    issue(5, 0, 2'b11, 7, 1, 0, 0); tick(); nop();
    @(negedge clk);
    n_cmp++; if (ex_fwd_sel !== 4'b0010) begin n_err++; $display("FAIL x0_sel: got %b expected 0010", ex_fwd_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(2, 0, 2'b01, 8, 1, 1, 0); tick();
    issue(8, 1, 2'b11, 9, 1, 0, 0);
    @(negedge clk);
    n_cmp++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b expected 1", stall_id); end
    tick();
    @(negedge clk);
    n_cmp++; if (stall_id !== 1'b0 || ex_fwd_sel !== 4'b0000) begin n_err++; $display("FAIL lu_bubble: got stall=%b sel=%b expected 0 0000", stall_id, ex_fwd_sel); end
    tick(); nop();
    @(negedge clk);
    n_cmp++; if (ex_fwd_sel !== 4'b0010) begin n_err++; $display("FAIL lu_sel: got %b expected 0010", ex_fwd_sel); end
    n_cmp++; if (perf_stall_cnt !== (PERF ? CW'(1) : CW'(0))) begin n_err++; $display("FAIL lu_cnt: got %0d expected %0d", perf_stall_cnt, PERF ? 1 : 0); end
  endtask

  task automatic test_store_bypass();
    do_reset();
    issue(2, 0, 2'b01, 8, 1, 1, 0); tick();
    issue(2, 8, 2'b11, 0, 0, 0, 1);
    @(negedge clk);
    n_cmp++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL sb_nostall: got %b expected 0", stall_id); end
    tick(); nop();
    @(negedge clk);
    n_cmp++; if (ex_fwd_sel !== 4'b0000 || mem_store_fwd !== 1'b0) begin n_err++; $display("FAIL sb_ex: got sel=%b msf=%b expected 0000 0", ex_fwd_sel, mem_store_fwd); end
    tick();
    @(negedge clk);
    n_cmp++; if (mem_store_fwd !== 1'b1) begin n_err++; $display("FAIL sb_msf: got %b expected 1", mem_store_fwd); end
    tick();
    @(negedge clk);
    n_cmp++; if (mem_store_fwd !== 1'b0) begin n_err++; $display("FAIL sb_msf_end: got %b expected 0", mem_store_fwd); end
    issue(2, 0, 2'b01, 8, 1, 1, 0); tick();
    issue(8, 2, 2'b11, 0, 0, 0, 1);
    @(negedge clk);
    n_cmp++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL sb_addr_stall: got %b expected 1", stall_id); end
    tick(); tick(); nop();
    @(negedge clk);
    n_cmp++; if (ex_fwd_sel !== 4'b0010) begin n_err++; $display("FAIL sb_addr_sel: got %b expected 0010", ex_fwd_sel); end
  endtask

  task automatic test_freeze();
    do_reset();
    issue(1, 1, 2'b11, 3, 1, 0, 0); tick();
    issue(3, 0, 2'b01, 8, 1, 1, 0); tick();
    issue(3, 0, 2'b01, 12, 1, 1, 0); tick();
    issue(12, 12, 2'b11, 13, 1, 0, 0);
    mem_ready = 1'b0; ex_flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (freeze !== 1'b1 || stall_id !== 1'b0) begin n_err++; $display("FAIL frz_%0d: got freeze=%b stall=%b expected 1 0", c, freeze, stall_id); end
      n_cmp++; if (ex_fwd_sel !== 4'b0010 || mem_store_fwd !== 1'b0) begin n_err++; $display("FAIL frz_hold_%0d: got sel=%b msf=%b expected 0010 0", c, ex_fwd_sel, mem_store_fwd); end
      tick();
    end
    mem_ready = 1'b1; ex_flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (freeze !== 1'b0 || stall_id !== 1'b1) begin n_err++; $display("FAIL frz_release: got freeze=%b stall=%b expected 0 1", freeze, stall_id); end
    n_cmp++; if (perf_freeze_cnt !== (PERF ? CW'(3) : CW'(0))) begin n_err++; $display("FAIL frz_cnt: got %0d expected %0d", perf_freeze_cnt, PERF ? 3 : 0); end
    tick(); nop();
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    issue(1, 1, 2'b11, 3, 1, 0, 0); tick();
    issue(1, 0, 2'b01, 8, 1, 1, 0); tick();
    issue(3, 0, 2'b01, 4, 1, 0, 0); tick();
    nop(); mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (freeze !== 1'b1 || ex_fwd_sel !== 4'b0010) begin n_err++; $display("FAIL rmf_pre: got freeze=%b sel=%b expected 1 0010", freeze, ex_fwd_sel); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (freeze !== 1'b0 || stall_id !== 1'b0 || ex_fwd_sel !== 4'b0000 || mem_store_fwd !== 1'b0)
      begin n_err++; $display("FAIL rmf_post: got freeze=%b stall=%b sel=%b msf=%b expected all 0", freeze, stall_id, ex_fwd_sel, mem_store_fwd); end
    n_cmp++; if (perf_stall_cnt !== '0 || perf_freeze_cnt !== '0) begin n_err++; $display("FAIL rmf_cnt: got %0d/%0d expected 0/0", perf_stall_cnt, perf_freeze_cnt); end
    mem_ready = 1'b1;
  endtask

  task automatic test_flush();
    do_reset();
    issue(2, 0, 2'b01, 8, 1, 1, 0); tick();
    issue(8, 1, 2'b11, 9, 1, 0, 0); ex_flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL fl_stall: got %b expected 1", stall_id); end
    tick(); ex_flush = 1'b0;
    issue(9, 9, 2'b11, 10, 1, 0, 0); tick(); nop();
    @(negedge clk);
    n_cmp++; if (ex_fwd_sel !== 4'b0000) begin n_err++; $display("FAIL fl_stall_sel: got %b expected 0000", ex_fwd_sel); end
    issue(1, 1, 2'b11, 5, 1, 0, 0); ex_flush = 1'b1; tick(); ex_flush = 1'b0;
    issue(5, 5, 2'b11, 6, 1, 0, 0); tick(); nop();
    @(negedge clk);
    n_cmp++; if (ex_fwd_sel !== 4'b0000) begin n_err++; $display("FAIL fl_only_sel: got %b expected 0000", ex_fwd_sel); end
  endtask

  task automatic test_random();
    logic [NS*SW-1:0] es;
    logic [CW-1:0] esc, efc;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      id_valid = ($urandom_range(0, 4) != 0);
      id_rs = {AW'($urandom_range(0, 5)), AW'($urandom_range(0, 5))};
      id_rs_used = NS'($urandom_range(0, 3));
      id_rd = AW'($urandom_range(0, 5));
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = ($urandom_range(0, 3) == 0);
      ex_flush = ($urandom_range(0, 9) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
      es = exp_sel();
      esc = PERF ? CW'(m_stall_cnt) : CW'(0);
      efc = PERF ? CW'(m_freeze_cnt) : CW'(0);
      n_cmp++; if (stall_id !== m_stall()) begin n_err++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, stall_id, m_stall()); end
      n_cmp++; if (freeze !== m_freeze()) begin n_err++; $display("FAIL rnd_freeze c%0d: got %b expected %b", c, freeze, m_freeze()); end
      n_cmp++; if (ex_fwd_sel !== es) begin n_err++; $display("FAIL rnd_sel c%0d: got %b expected %b", c, ex_fwd_sel, es); end
      n_cmp++; if (mem_store_fwd !== (m_pipe[1].v && m_pipe[1].sf)) begin n_err++; $display("FAIL rnd_msf c%0d: got %b expected %b", c, mem_store_fwd, m_pipe[1].v && m_pipe[1].sf); end
      n_cmp++; if (perf_stall_cnt !== esc || perf_freeze_cnt !== efc) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d/%0d expected %0d/%0d", c, perf_stall_cnt, perf_freeze_cnt, esc, efc); end
      tick();
    end
    rst_n = 1'b1; mem_ready = 1'b1; ex_flush = 1'b0; nop();
  endtask

  initial begin
    for (int k = 0; k <= D; k++) m_pipe[k] = '{default: 0};
    m_sel = '{0, 0};
    #1;
    test_reset();
    test_fwd_alu();
    test_fwd_x0();
    test_load_use();
    test_store_bypass();
    test_freeze();
    test_reset_mid_freeze();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
